// File: rtl/arb_data_mem_pkg.sv
// Shared types and sizing helpers for the arbitrated data memory and its arbiter.
package arb_data_mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    localparam int DEF_N_PORTS = 2;
    localparam int DEF_PTR_W   = $clog2(DEF_N_PORTS);

    function automatic int byte_count(input int data_w);
        return data_w / 8;
    endfunction

    // A single-channel build still needs a 1-bit pointer.
    function automatic int ptr_width(input int n_ports);
        return (n_ports > 1) ? $clog2(n_ports) : 1;
    endfunction

endpackage

// File: rtl/arb_data_mem_rr_arbiter.sv
// Round-robin arbiter: the first request at or after i_ptr wins, wrapping to channel 0.
module rr_arbiter
    import arb_data_mem_pkg::*;
#(
    parameter int N_PORTS = DEF_N_PORTS,
    parameter int PTR_W   = DEF_PTR_W
) (
    input  logic [N_PORTS-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [N_PORTS-1:0] o_gnt,
    output logic [PTR_W-1:0]   o_winner,
    output logic               o_valid
);

    logic [N_PORTS-1:0] w_hi;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch is inferred.
        w_hi = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            w_hi[i] = i_req[i] && (i >= int'(i_ptr));
        end
    end

    // Scanning downwards leaves the lowest qualifying index as the winner.
    always_comb begin
        o_gnt    = '0;
        o_winner = '0;
        o_valid  = |i_req;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            if ((w_hi == '0) ? i_req[i] : w_hi[i]) begin
                o_gnt    = '0;
                o_gnt[i] = 1'b1;
                o_winner = PTR_W'(i);
            end
        end
    end

endmodule

// File: rtl/arb_data_mem.sv
// Multi-channel shared data memory: round-robin grant, byte-enabled writes, RD_LAT read path.
module arb_data_mem
    import arb_data_mem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 4,
    parameter int N_PORTS = DEF_N_PORTS,
    parameter int RD_LAT  = 1
) (
    input  logic                          clk,
    input  logic                          n_reset,
    input  logic [N_PORTS-1:0]            req,
    input  logic [N_PORTS-1:0]            we,
    input  logic [N_PORTS*ADDR_W-1:0]     addr,
    input  logic [N_PORTS*DATA_W-1:0]     wdata,
    input  logic [N_PORTS*(DATA_W/8)-1:0] be,
    output logic [N_PORTS-1:0]            gnt,
    output logic [N_PORTS-1:0]            rvalid,
    output logic [DATA_W-1:0]             rdata,
    output logic                          busy
);

    localparam int NB    = byte_count(DATA_W);
    localparam int PTR_W = ptr_width(N_PORTS);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = 2;

    state_t             r_state;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_owner;
    logic [ADDR_W-1:0]  r_raddr;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_mem [DEPTH];

    logic [N_PORTS-1:0] w_arb_gnt;
    logic [PTR_W-1:0]   w_winner;
    logic [PTR_W-1:0]   w_ptr_next;
    logic               w_arb_valid;
    logic               w_free;
    logic               w_done;
    logic               w_grant;
    logic               w_win_we;
    logic [ADDR_W-1:0]  w_win_addr;
    logic [DATA_W-1:0]  w_win_wdata;
    logic [NB-1:0]      w_win_be;

    // The last read cycle frees the memory, so a waiting channel is granted alongside rvalid.
    assign w_done  = (r_state == READ) && (r_cnt == '0);
    assign w_free  = n_reset && ((r_state == IDLE) || w_done);
    assign w_grant = w_free && w_arb_valid;

    rr_arbiter #(
        .N_PORTS (N_PORTS),
        .PTR_W   (PTR_W)
    ) u_arb (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_gnt    (w_arb_gnt),
        .o_winner (w_winner),
        .o_valid  (w_arb_valid)
    );

    assign gnt         = w_free ? w_arb_gnt : '0;
    assign w_win_we    = we[w_winner];
    assign w_win_addr  = addr[w_winner*ADDR_W +: ADDR_W];
    assign w_win_wdata = wdata[w_winner*DATA_W +: DATA_W];
    assign w_win_be    = be[w_winner*NB +: NB];
    assign w_ptr_next  = (w_winner == PTR_W'(N_PORTS - 1)) ? '0 : w_winner + 1'b1;

    assign busy  = (r_state == READ) && (r_cnt != '0);
    assign rdata = w_done ? r_mem[r_raddr] : '0;

    always_comb begin
        rvalid = '0;
        if (w_done) begin
            rvalid[r_owner] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (!n_reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_raddr <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                READ: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
            if (w_grant) begin
                r_ptr <= w_ptr_next;
                if (!w_win_we) begin
                    r_state <= READ;
                    r_owner <= w_winner;
                    r_raddr <= w_win_addr;
                    r_cnt   <= CNT_W'(RD_LAT - 1);
                end
            end
        end
    end

    // NOTE: the storage array has no reset; it is plain RAM and holds its contents across reset.
    always_ff @(posedge clk) begin
        if (w_grant && w_win_we) begin
            for (int b = 0; b < NB; b++) begin
                if (w_win_be[b]) begin
                    r_mem[w_win_addr][b*8 +: 8] <= w_win_wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_arb_data_mem.sv
// Bench for arb_data_mem: one instance with RD_LAT=1 and one with RD_LAT=3, scoreboarded reads.
module tb_arb_data_mem;

    typedef struct {
        int          dut;
        int          ch;
        logic [31:0] data;
        int          due;
    } exp_t;

    typedef struct {
        int          ch;
        bit          w;
        logic [3:0]  a;
        logic [31:0] d;
        logic [3:0]  b;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        n_rst [2];
    logic [1:0]  req_v [2];
    logic [1:0]  we_v [2];
    logic [7:0]  addr_v [2];
    logic [63:0] wdata_v [2];
    logic [7:0]  be_v [2];
    logic [1:0]  gnt_v [2];
    logic [1:0]  rvalid_v [2];
    logic [31:0] rdata_v [2];
    logic        busy_v [2];

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t sb[$];
    vec_t tbl[12];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    arb_data_mem #(.DATA_W(32), .ADDR_W(4), .N_PORTS(2), .RD_LAT(1)) u_dut_l1 (
        .clk(clk), .n_reset(n_rst[0]), .req(req_v[0]), .we(we_v[0]), .addr(addr_v[0]),
        .wdata(wdata_v[0]), .be(be_v[0]), .gnt(gnt_v[0]), .rvalid(rvalid_v[0]),
        .rdata(rdata_v[0]), .busy(busy_v[0])
    );

    arb_data_mem #(.DATA_W(32), .ADDR_W(4), .N_PORTS(2), .RD_LAT(3)) u_dut_l3 (
        .clk(clk), .n_reset(n_rst[1]), .req(req_v[1]), .we(we_v[1]), .addr(addr_v[1]),
        .wdata(wdata_v[1]), .be(be_v[1]), .gnt(gnt_v[1]), .rvalid(rvalid_v[1]),
        .rdata(rdata_v[1]), .busy(busy_v[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Read completions are matched against the scoreboard on every falling edge.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rvalid_v[d] != 2'b00) begin
                if (sb.size() == 0) begin
                    check("rv_unexpected", 64'(rvalid_v[d]), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rv_dut", 64'(d), 64'(e.dut));
                    check("rv_onehot", 64'(rvalid_v[d]), 64'(1) << e.ch);
                    check("rv_data", 64'(rdata_v[d]), 64'(e.data));
                    check("rv_cycle", 64'(cyc), 64'(e.due));
                end
            end else begin
                check("rdata_idle", 64'(rdata_v[d]), 64'd0);
            end
        end
    end

    task automatic set_ch(input int d, input int ch, input bit r, input bit w,
                          input logic [3:0] a, input logic [31:0] wd, input logic [3:0] b);
        req_v[d][ch]           = r;
        we_v[d][ch]            = w;
        addr_v[d][ch*4 +: 4]   = a;
        wdata_v[d][ch*32 +: 32] = wd;
        be_v[d][ch*4 +: 4]     = b;
    endtask

    task automatic wait_gnt(input int d, input int ch, output int waited, output bit ok);
        ok     = 1'b0;
        waited = 0;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (gnt_v[d][ch]) begin
                ok     = 1'b1;
                waited = i;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("gnt_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_req(input int d, input int ch, input bit w, input logic [3:0] a,
                          input logic [31:0] wd, input logic [3:0] b, input logic [31:0] expd,
                          output int waited);
        bit ok;
        set_ch(d, ch, 1'b1, w, a, wd, b);
        wait_gnt(d, ch, waited, ok);
        if (ok) begin
            check("gnt_onehot", 64'(gnt_v[d]), 64'(1) << ch);
            if (!w) sb.push_back('{d, ch, expd, cyc + lat(d)});
        end
        @(negedge clk);
        set_ch(d, ch, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
    endtask

    // Both channels read at once; 'first' must win now, the other once the memory frees up.
    task automatic tie(input int d, input int first, input logic [3:0] a0, input logic [3:0] a1,
                       input logic [31:0] e0, input logic [31:0] e1);
        int waited;
        bit ok;
        int second;
        second = 1 - first;
        set_ch(d, 0, 1'b1, 1'b0, a0, 32'd0, 4'd0);
        set_ch(d, 1, 1'b1, 1'b0, a1, 32'd0, 4'd0);
        #1;
        check("tie_first", 64'(gnt_v[d]), 64'(1) << first);
        check("tie_busy0", 64'(busy_v[d]), 64'd0);
        sb.push_back('{d, first, (first == 0) ? e0 : e1, cyc + lat(d)});
        @(negedge clk);
        set_ch(d, first, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
        wait_gnt(d, second, waited, ok);
        if (ok) begin
            check("tie_second", 64'(gnt_v[d]), 64'(1) << second);
            check("tie_wait", 64'(waited), 64'(lat(d) - 1));
            sb.push_back('{d, second, (second == 0) ? e0 : e1, cyc + lat(d)});
        end
        @(negedge clk);
        set_ch(d, second, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
    endtask

    task automatic reset_dut(input int d);
        n_rst[d] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_rst[d] = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        logic [31:0] b2b [3];

        tbl[0]  = '{0, 1'b1, 4'd3,  32'hDEADBEEF, 4'hF, 32'h0};
        tbl[1]  = '{1, 1'b0, 4'd3,  32'h0,        4'h0, 32'hDEADBEEF};
        tbl[2]  = '{0, 1'b1, 4'd5,  32'h11223344, 4'hF, 32'h0};
        tbl[3]  = '{1, 1'b1, 4'd5,  32'hAABBCCDD, 4'h5, 32'h0};
        tbl[4]  = '{0, 1'b0, 4'd5,  32'h0,        4'h0, 32'h11BB33DD};
        tbl[5]  = '{1, 1'b1, 4'd7,  32'h01234567, 4'hF, 32'h0};
        tbl[6]  = '{0, 1'b1, 4'd7,  32'hFFFFFFFF, 4'h0, 32'h0};
        tbl[7]  = '{1, 1'b0, 4'd7,  32'h0,        4'h0, 32'h01234567};
        tbl[8]  = '{0, 1'b1, 4'd0,  32'hA5A5A5A5, 4'hF, 32'h0};
        tbl[9]  = '{1, 1'b1, 4'd15, 32'h5A5AC3C3, 4'hF, 32'h0};
        tbl[10] = '{0, 1'b0, 4'd0,  32'h0,        4'h0, 32'hA5A5A5A5};
        tbl[11] = '{1, 1'b0, 4'd15, 32'h0,        4'h0, 32'h5A5AC3C3};
        b2b[0] = 32'hB2B00001;
        b2b[1] = 32'hB2B00002;
        b2b[2] = 32'hB2B00003;

        for (int d = 0; d < 2; d++) begin
            n_rst[d] = 1'b1;
            req_v[d] = '0; we_v[d] = '0; addr_v[d] = '0; wdata_v[d] = '0; be_v[d] = '0;
        end
        #1;
        n_rst[0] = 1'b0;
        n_rst[1] = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_gnt", 64'(gnt_v[d]), 64'd0);
            check("rst_rvalid", 64'(rvalid_v[d]), 64'd0);
            check("rst_rdata", 64'(rdata_v[d]), 64'd0);
            check("rst_busy", 64'(busy_v[d]), 64'd0);
        end
        @(negedge clk);
        @(negedge clk);
        n_rst[0] = 1'b1;
        n_rst[1] = 1'b1;
        @(negedge clk);

        // Table: writes, byte enables, be=0, boundary addresses, read-after-write.
        for (int i = 0; i < 12; i++) begin
            do_req(0, tbl[i].ch, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].b, tbl[i].exp, waited);
            check("tbl_wait", 64'(waited), 64'd0);
        end

        // Back-to-back writes on ch1 with req held.
        for (int i = 0; i < 3; i++) begin
            set_ch(0, 1, 1'b1, 1'b1, 4'(i + 1), b2b[i], 4'hF);
            #1;
            check("b2b_gnt", 64'(gnt_v[0]), 64'b10);
            @(negedge clk);
        end
        set_ch(0, 1, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            do_req(0, 0, 1'b0, 4'(i + 1), 32'd0, 4'd0, b2b[i], waited);
        end
        repeat (3) @(negedge clk);

        // Contention from reset, then a tie after a lone ch0 grant.
        reset_dut(0);
        tie(0, 0, 4'd5, 4'd7, 32'h11BB33DD, 32'h01234567);
        do_req(0, 0, 1'b1, 4'd8, 32'h88888888, 4'hF, 32'd0, waited);
        tie(0, 1, 4'd5, 4'd7, 32'h11BB33DD, 32'h01234567);
        repeat (3) @(negedge clk);

        // RD_LAT=3 instance: preload, then latency with ch1 waiting.
        do_req(1, 0, 1'b1, 4'd0, 32'h0BADF00D, 4'hF, 32'd0, waited);
        do_req(1, 1, 1'b1, 4'd9, 32'h99990009, 4'hF, 32'd0, waited);
        set_ch(1, 0, 1'b1, 1'b0, 4'd0, 32'd0, 4'd0);
        #1;
        check("lat_gnt0", 64'(gnt_v[1]), 64'b01);
        sb.push_back('{1, 0, 32'h0BADF00D, cyc + 3});
        @(negedge clk);
        set_ch(1, 0, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
        set_ch(1, 1, 1'b1, 1'b0, 4'd9, 32'd0, 4'd0);
        for (int k = 0; k < 2; k++) begin
            #1;
            check("lat_hold_gnt", 64'(gnt_v[1]), 64'd0);
            check("lat_busy", 64'(busy_v[1]), 64'd1);
            @(negedge clk);
        end
        #1;
        check("lat_gnt1", 64'(gnt_v[1]), 64'b10);
        check("lat_busy_done", 64'(busy_v[1]), 64'd0);
        sb.push_back('{1, 1, 32'h99990009, cyc + 3});
        @(negedge clk);
        set_ch(1, 1, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
        repeat (5) @(negedge clk);

        // Reset during a read with ptr left at 1 and ch1 waiting.
        do_req(1, 0, 1'b1, 4'd4, 32'h44444444, 4'hF, 32'd0, waited);
        set_ch(1, 0, 1'b1, 1'b0, 4'd0, 32'd0, 4'd0);
        #1;
        check("mid_gnt0", 64'(gnt_v[1]), 64'b01);
        @(negedge clk);
        set_ch(1, 0, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
        set_ch(1, 1, 1'b1, 1'b0, 4'd9, 32'd0, 4'd0);
        #1;
        check("mid_busy", 64'(busy_v[1]), 64'd1);
        #1;
        n_rst[1] = 1'b0;
        #1;
        check("mid_rst_gnt", 64'(gnt_v[1]), 64'd0);
        check("mid_rst_rvalid", 64'(rvalid_v[1]), 64'd0);
        check("mid_rst_busy", 64'(busy_v[1]), 64'd0);
        check("mid_rst_rdata", 64'(rdata_v[1]), 64'd0);
        set_ch(1, 1, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
        @(negedge clk);
        @(negedge clk);
        n_rst[1] = 1'b1;
        repeat (5) @(negedge clk);
        tie(1, 0, 4'd0, 4'd9, 32'h0BADF00D, 32'h99990009);
        repeat (6) @(negedge clk);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
